// File: rtl/iob_dma_write.sv
// iob_dma_write
//   Write-direction DMA engine. Words arriving on an AXI-Stream input are
//   buffered in an internal first-word-fall-through FIFO and drained to
//   memory with AXI4 INCR write bursts, one burst outstanding at a time.
//
// Ports
//   clk_i, cke_i, rst_n_i    clock, clock enable (all state holds when low),
//                            synchronous active-low reset
//   w_addr_i                 start byte address (bus-word aligned)
//   w_length_i               transfer length in words
//   w_start_transfer_i       start pulse (ignored while busy)
//   w_max_len_i              max burst length in words (0 treated as 1)
//   w_remaining_data_o       words not yet acknowledged on the B channel
//   w_busy_o, w_error_o      transfer in progress / sticky bad bresp seen
//   axis_in_*                AXI-Stream slave input
//   m_axi_aw*, m_axi_w*, m_axi_b*   AXI4 write master channels
module iob_dma_write #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int DMA_WLEN_W = 16
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_n_i,
  input  logic [AXI_ADDR_W-1:0]   w_addr_i,
  input  logic [DMA_WLEN_W-1:0]   w_length_i,
  input  logic                    w_start_transfer_i,
  input  logic [AXI_LEN_W:0]      w_max_len_i,
  output logic [DMA_WLEN_W-1:0]   w_remaining_data_o,
  output logic                    w_busy_o,
  output logic                    w_error_o,
  input  logic [AXI_DATA_W-1:0]   axis_in_tdata_i,
  input  logic                    axis_in_tvalid_i,
  output logic                    axis_in_tready_o,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int DEPTH  = 2 ** AXI_LEN_W;
  localparam int LVL_W  = AXI_LEN_W + 1;
  localparam int SIZE   = $clog2(AXI_DATA_W / 8);
  localparam logic [LVL_W-1:0] DEPTH_L = {1'b1, {AXI_LEN_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [AXI_ADDR_W-1:0] addr;
  logic [DMA_WLEN_W-1:0] remaining;
  logic [DMA_WLEN_W-1:0] accept_cnt;
  logic [LVL_W-1:0]      burst_len;
  logic [LVL_W-1:0]      beat;
  logic                  error;

  logic [AXI_DATA_W-1:0] mem [DEPTH];
  logic [AXI_LEN_W-1:0]  wr_ptr;
  logic [AXI_LEN_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  busy;
  logic                  push;
  logic                  pop;
  logic                  last_beat;
  logic [LVL_W-1:0]      len_m1;
  logic [LVL_W-1:0]      max_eff;
  logic [DMA_WLEN_W-1:0] max_wide;
  logic [DMA_WLEN_W-1:0] level_wide;
  logic [LVL_W-1:0]      burst_sel;
  logic                  unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign busy       = (state != IDLE);
  assign fifo_full  = (level == DEPTH_L);
  assign fifo_empty = (level == '0);
  assign len_m1     = burst_len - LVL_W'(1);
  assign last_beat  = (beat == len_m1);

  assign push = busy && !fifo_full && (accept_cnt != '0) && axis_in_tvalid_i;
  assign pop  = (state == DATA) && !fifo_empty && m_axi_wready;

  // Out-of-range max lengths are clamped so a burst can always be formed
  // from a FIFO that fits at most DEPTH words.
  always_comb begin
    max_eff = w_max_len_i;
    if (w_max_len_i == '0) begin
      max_eff = LVL_W'(1);
    end else if (w_max_len_i > DEPTH_L) begin
      max_eff = DEPTH_L;
    end
  end

  assign max_wide   = DMA_WLEN_W'(max_eff);
  assign level_wide = DMA_WLEN_W'(level);

  // Burst length is only chosen once every word of it is already buffered,
  // so the W channel never waits on the stream mid-burst.
  always_comb begin
    burst_sel = '0;
    if ((remaining <= max_wide) && (level_wide >= remaining)) begin
      burst_sel = LVL_W'(remaining);
    end else if (level >= max_eff) begin
      burst_sel = max_eff;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        state <= IDLE;
      end else begin
        state <= state_nxt;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    m_axi_awvalid    = 1'b0;
    m_axi_wvalid     = 1'b0;
    m_axi_wlast      = 1'b0;
    m_axi_bready     = 1'b0;
    unique case (state)
      IDLE: begin
        if (w_start_transfer_i) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (remaining == '0) begin
          state_nxt = IDLE;
        end else if (burst_sel != '0) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = DATA;
      end
      DATA: begin
        m_axi_wvalid = !fifo_empty;
        m_axi_wlast  = last_beat;
        if (pop && last_beat) state_nxt = RESP;
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = WAIT_DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        addr       <= '0;
        remaining  <= '0;
        accept_cnt <= '0;
        burst_len  <= '0;
        beat       <= '0;
        error      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (w_start_transfer_i) begin
              addr       <= w_addr_i;
              remaining  <= w_length_i;
              accept_cnt <= w_length_i;
              error      <= 1'b0;
            end
          end
          WAIT_DATA: begin
            if ((remaining != '0) && (burst_sel != '0)) begin
              burst_len <= burst_sel;
              beat      <= '0;
            end
          end
          DATA: begin
            if (pop) beat <= beat + LVL_W'(1);
          end
          RESP: begin
            if (m_axi_bvalid) begin
              remaining <= remaining - DMA_WLEN_W'(burst_len);
              addr      <= addr + (AXI_ADDR_W'(burst_len) << SIZE);
              error     <= error | (m_axi_bresp != 2'b00);
            end
          end
          default: ;
        endcase
        if (push) accept_cnt <= accept_cnt - DMA_WLEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AXI_LEN_W'(1);
        if (pop)  rd_ptr <= rd_ptr + AXI_LEN_W'(1);
        unique case ({push, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && push) mem[wr_ptr] <= axis_in_tdata_i;
  end

  assign m_axi_wdata        = mem[rd_ptr];
  assign m_axi_wstrb        = '1;
  assign m_axi_awaddr       = addr;
  assign m_axi_awlen        = len_m1[AXI_LEN_W-1:0];
  assign m_axi_awsize       = 3'(SIZE);
  assign m_axi_awburst      = 2'b01;
  assign m_axi_awid         = '0;
  assign axis_in_tready_o   = busy && !fifo_full && (accept_cnt != '0);
  assign w_remaining_data_o = remaining;
  assign w_busy_o           = busy;
  assign w_error_o          = error;

endmodule

// File: tb/tb_iob_dma_write.sv
module tb_iob_dma_write;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int IW = 1;
  localparam int WL = 16;
  localparam int DEPTH = 1 << LW;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic cke, rst_n;
  logic [AW-1:0] w_addr;
  logic [WL-1:0] w_length;
  logic          w_start;
  logic [LW:0]   w_max;
  logic [WL-1:0] w_rem;
  logic          w_busy, w_err;
  logic [DW-1:0] tdata;
  logic          tvalid, tready;
  logic [AW-1:0] awaddr;
  logic [LW-1:0] awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [IW-1:0] awid;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;

  iob_dma_write #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW),
                  .AXI_ID_W(IW), .DMA_WLEN_W(WL)) dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
    .w_addr_i(w_addr), .w_length_i(w_length), .w_start_transfer_i(w_start),
    .w_max_len_i(w_max), .w_remaining_data_o(w_rem), .w_busy_o(w_busy),
    .w_error_o(w_err),
    .axis_in_tdata_i(tdata), .axis_in_tvalid_i(tvalid), .axis_in_tready_o(tready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awid(awid), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int unsigned max_eff(input int unsigned m);
    if (m == 0) return 1;
    if (m > DEPTH) return DEPTH;
    return m;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Stimulus/slave control
  logic [31:0] src_q[$];
  bit full_rate;
  int wready_hold = 0;
  int err_b = -1;
  int b_idx = 0;
  int pending_b = 0;
  bit run = 0;

  // Reference model state
  bit          m_busy, m_idle_next, m_err;
  int unsigned m_rem, m_len, m_acc, m_pop, m_L, m_beat;
  int          m_phase;   // 0: no burst, 1: data beats due, 2: response due
  logic [31:0] m_addr;
  logic [31:0] exp_w[$];
  logic [31:0] aw_addr_log[$];
  int unsigned aw_len_log[$];
  bit          aw_pend;
  logic [31:0] aw_pend_addr;
  logic [LW-1:0] aw_pend_len;
  int unsigned last_busy;

  // Compare process: checks DUT outputs against the model, then applies the
  // handshakes visible now (they take effect at the next rising edge).
  always @(negedge clk) begin
    bit was_busy;
    bit aw_ok;
    int unsigned want_L;
    if (!rst_n) begin
      m_busy = 0; m_idle_next = 0; m_err = 0; m_rem = 0; m_len = 0;
      m_acc = 0; m_pop = 0; m_L = 0; m_beat = 0; m_phase = 0; m_addr = 0;
      exp_w.delete(); aw_pend = 0;
    end else if (run) begin
      want_L = min_u(m_rem, max_eff(w_max));
      chk("busy", w_busy, m_busy);
      chk("remaining", w_rem, m_rem);
      chk("error", w_err, m_err);
      chk("tready", tready, m_busy && (m_acc < m_len) && ((m_acc - m_pop) < DEPTH));
      chk("wvalid", wvalid, m_phase == 1);
      chk("bready", bready, m_phase == 2);
      aw_ok = m_busy && (m_phase == 0) && (m_rem != 0) && ((m_acc - m_pop) >= want_L);
      if (!aw_ok) chk("awvalid_premature", awvalid, 0);
      if (aw_pend) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, aw_pend_addr);
        chk("aw_hold_len", awlen, aw_pend_len);
      end
      if (awvalid) begin
        chk("awaddr", awaddr, m_addr);
        chk("awlen", awlen, want_L - 1);
        chk("awsize", awsize, 2);
        chk("awburst", awburst, 1);
        chk("awid", awid, 0);
      end
      if (wvalid) chk("wstrb", wstrb, 4'hF);
      if (wvalid && wready) begin
        if (exp_w.size() == 0) chk("w_unexpected_beat", wvalid, 0);
        else chk("wdata", wdata, exp_w.pop_front());
        chk("wlast", wlast, m_beat == m_L - 1);
      end

      was_busy = m_busy;
      if (m_idle_next) begin m_busy = 0; m_idle_next = 0; end
      if (w_start && !was_busy) begin
        m_busy = 1; m_rem = w_length; m_len = w_length; m_acc = 0; m_pop = 0;
        m_err = 0; m_addr = w_addr; m_phase = 0; exp_w.delete();
        aw_addr_log.delete(); aw_len_log.delete();
        m_idle_next = (w_length == 0);
      end
      if (tvalid && tready) begin exp_w.push_back(tdata); m_acc++; end
      if (awvalid && awready) begin
        m_L = want_L; m_beat = 0; m_phase = 1;
        aw_addr_log.push_back(awaddr); aw_len_log.push_back(awlen);
      end
      if (wvalid && wready) begin
        m_pop++; m_beat++;
        if (m_beat == m_L) m_phase = 2;
      end
      if (bvalid && bready) begin
        m_rem -= m_L; m_addr += m_L * 4;
        if (bresp != 2'b00) m_err = 1;
        m_phase = 0;
        if (m_rem == 0) m_idle_next = 1;
      end
      aw_pend = awvalid && !awready;
      aw_pend_addr = awaddr;
      aw_pend_len = awlen;
    end
  end

  // Stream source and memory slave
  initial begin
    bit s_hs, wl_hs, b_hs, rst_seen;
    tvalid = 0; tdata = '0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
    forever begin
      @(negedge clk);
      rst_seen = !rst_n;
      s_hs  = tvalid && tready && !rst_seen;
      wl_hs = wvalid && wready && wlast && !rst_seen;
      b_hs  = bvalid && bready && !rst_seen;
      @(posedge clk); #1;
      if (s_hs && src_q.size() > 0) src_q.delete(0);
      if (wl_hs) pending_b++;
      if (b_hs) begin pending_b--; b_idx++; end
      if (rst_seen) begin pending_b = 0; bvalid = 0; end
      if (!(tvalid && !s_hs && src_q.size() > 0))
        tvalid = (src_q.size() > 0) && (full_rate || $urandom_range(0, 99) < 70);
      tdata = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
      awready = full_rate || ($urandom_range(0, 99) < 60);
      if (wready_hold > 0) begin wready = 0; wready_hold--; end
      else wready = full_rate || ($urandom_range(0, 99) < 60);
      if (!(bvalid && !b_hs)) begin
        bvalid = (pending_b > 0) && (full_rate || $urandom_range(0, 99) < 50);
        bresp = (b_idx == err_b) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic kick(input logic [31:0] a, input int unsigned len, input int unsigned mx,
                      input bit fr, input int unsigned extra, input int eb);
    full_rate = fr; err_b = eb; b_idx = 0;
    for (int unsigned i = 0; i < len + extra; i++) src_q.push_back($urandom);
    @(posedge clk); #1;
    w_addr = a; w_length = WL'(len); w_max = (LW+1)'(mx); w_start = 1;
    @(posedge clk); #1;
    w_start = 0;
  endtask

  task automatic do_transfer(input logic [31:0] a, input int unsigned len, input int unsigned mx,
                             input bit fr, input int unsigned extra, input int eb,
                             input int stall, input bit probe);
    int unsigned cnt, me, nb;
    kick(a, len, mx, fr, extra, eb);
    if (stall > 0) wready_hold = stall;
    chk("rem_at_start", w_rem, len);
    chk("busy_at_start", w_busy, 1);
    chk("err_at_start", w_err, 0);
    cnt = 0;
    while (w_busy && cnt < BUDGET) begin
      if (probe && cnt == 30) chk("stall_full_tready", tready, 0);
      @(posedge clk); #1;
      cnt++;
    end
    last_busy = cnt;
    chk("transfer_timeout", w_busy, 0);
    me = max_eff(mx);
    nb = (len + me - 1) / me;
    chk("aw_count", aw_addr_log.size(), nb);
    chk("words_accepted", m_acc, len);
    chk("extra_words_left", src_q.size(), extra);
    chk("w_leftover", exp_w.size(), 0);
    src_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned cnt, ln, mx;
    cke = 1; rst_n = 0; w_start = 0; w_addr = '0; w_length = '0; w_max = '0;
    full_rate = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1; run = 1;
    chk("rst_busy", w_busy, 0);
    chk("rst_rem", w_rem, 0);
    chk("rst_err", w_err, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_tready", tready, 0);

    // 1: two bursts of four
    do_transfer(32'h100, 8, 4, 1, 2, -1, 0, 0);
    chk("t1_aw0_addr", aw_addr_log[0], 32'h100);
    chk("t1_aw0_len", aw_len_log[0], 3);
    chk("t1_aw1_addr", aw_addr_log[1], 32'h110);
    chk("t1_aw1_len", aw_len_log[1], 3);

    // 2: single short burst
    do_transfer(32'h400, 5, 16, 0, 1, -1, 0, 0);
    chk("t2_aw0_len", aw_len_log[0], 4);

    // 3: zero length
    do_transfer(32'h800, 0, 4, 1, 2, -1, 0, 0);
    chk("t3_busy_cycles", last_busy, 1);

    // 4: FIFO fills while the slave stalls W
    do_transfer(32'h1000, 2 * DEPTH, DEPTH, 1, 0, -1, 50, 1);
    chk("t4_aw1_addr", aw_addr_log[1], 32'h1040);

    // 5: error on second response is sticky
    do_transfer(32'h3000, 12, 4, 1, 0, 1, 0, 0);
    chk("t5_error_set", w_err, 1);
    repeat (5) @(posedge clk); #1;
    chk("t5_error_sticky", w_err, 1);

    // 6: reset during DATA
    kick(32'h2000, 12, 4, 1, 0, -1);
    cnt = 0;
    while (!wvalid && cnt < 200) begin @(posedge clk); #1; cnt++; end
    chk("t6_reach_data", wvalid, 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("t6_awvalid", awvalid, 0);
    chk("t6_wvalid", wvalid, 0);
    chk("t6_bready", bready, 0);
    chk("t6_busy", w_busy, 0);
    chk("t6_rem", w_rem, 0);
    chk("t6_tready", tready, 0);
    src_q.delete();
    repeat (3) @(posedge clk); #1;
    do_transfer(32'h2000, 7, 3, 0, 1, -1, 0, 0);

    // address wrap and max_len 0
    do_transfer(32'hFFFF_FFF8, 6, 2, 0, 0, -1, 0, 0);
    chk("wrap_aw1_addr", aw_addr_log[1], 32'h0);
    chk("wrap_aw2_addr", aw_addr_log[2], 32'h8);
    do_transfer(32'h5000, 3, 0, 0, 0, -1, 0, 0);
    chk("max0_aw0_len", aw_len_log[0], 0);

    // randomized transfers
    for (int i = 0; i < 8; i++) begin
      ln = $urandom_range(1, 40);
      mx = $urandom_range(1, DEPTH);
      do_transfer({$urandom_range(0, 32'hFFFF), 2'b00}, ln, mx, 0,
                  $urandom_range(0, 3), $urandom_range(0, 3) - 1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
